dmem_sized: RTL and testbench
=============================

# dmem_sized

Byte-addressable, parametrised-depth data memory for the pipeline's MEM stage. It supports byte, half-word and word loads and stores, with sign or zero extension on loads. Alignment and range faults are flagged. Every accepted request gets a registered response one cycle later. After reset, a built-in init sequencer zeroes the array, so large depths need no reset fan-out.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, ≥ 2.
- ADDR_W, 32: byte-address width; must satisfy ADDR_W ≥ $clog2(DEPTH_WORDS)+2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; this is the only reset.
- req_valid  in  1  request present.
- req_ready  out  1  request may be accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and faults.
- rsp_err  out  1  fault on this response (misaligned, out of range or reserved size).
- init_done  out  1  array zeroing complete.

## Operation
- FSM states: INIT, RUN.
- Reset asserted (asynchronously): state = INIT, init counter = 0, and all outputs are 0.
  - In-flight responses are dropped.
  - Reset mid-operation restarts zeroing from word 0.
- INIT: each clk edge writes 0 to word[counter], then increments the counter.
  - After the edge that writes word DEPTH_WORDS-1: state = RUN, init_done = 1.
  - Requests are never accepted in INIT.
- RUN: req_ready = 1 continuously, so the block takes one request per cycle with no bubbles.
- Acceptance happens on a clk edge when req_valid && req_ready.
- Word index = req_addr[IDX+1:2], where IDX = $clog2(DEPTH_WORDS). Lane = req_addr[1:0]. Layout is little-endian.
- Fault if any of the following:
  - req_size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - req_addr ≥ DEPTH_WORDS*4.
- Faulting requests do not modify the array and return rsp_rdata = 0 with rsp_err = 1.
- Stores:
  - byte: writes lane addr[1:0] with wdata[7:0];
  - half: writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - word: writes all lanes.
  - Unaddressed lanes are unchanged.
- Loads: extract the addressed byte or half from the word, then sign- or zero-extend per req_unsigned. Word loads ignore req_unsigned.
- Address 0 is an ordinary location; it is not write-protected.

## Timing
- Latency is 1 cycle: a request accepted at edge N produces rsp_valid = 1 for exactly the cycle following edge N.
  - rsp_rdata and rsp_err are registered and valid only while rsp_valid = 1.
  - Outside that cycle they read 0.
- There is no response backpressure; the consumer must take each response in its valid cycle.
- A store accepted at edge N is visible to a load accepted at edge N+1. Back-to-back store→load to the same word returns the new data.
- init_done and req_ready rise DEPTH_WORDS edges after reset deasserts and stay high until the next reset.
- Stores produce a response too: rsp_valid = 1, rsp_rdata = 0, rsp_err as computed.

## Structure
- Package dmem_pkg holds:
  - typedef enum logic [1:0] mem_size_e {MEM_B, MEM_H, MEM_W, MEM_RSVD};
  - typedef enum logic dmem_state_e {INIT, RUN};
  - the fault-check function.
- Sub-module dmem_load_align (combinational) takes the word, lane, size and unsigned flag, and returns the extended 32-bit result.
- The array is reg [31:0] mem [DEPTH_WORDS], written through per-lane byte enables.

## Test plan
All scenarios use DEPTH_WORDS = 256.
- Init: release reset, then hold req_valid. Required: req_ready = 0 for 256 cycles, then 1; a word load at 0x3FC returns 0x00000000.
- Sized store/load: store word 0xDEADBEEF at 0x10, then load byte 0x13 signed → 0xFFFFFFDE. Continue:
  - load byte 0x13 unsigned → 0x000000DE;
  - load half 0x10 signed → 0xFFFFBEEF;
  - store byte 0xAA at 0x11, then load word 0x10 → 0xDEADAAEF.
- Faults: store half at 0x21 and store word at 0x400 → each rsp_err = 1, and a word load of 0x20 returns its prior value. Also load with size 11 → rsp_err = 1, rsp_rdata = 0.
- Back-to-back: word store 0x12345678 at 0x40 in cycle k, word load 0x40 in cycle k+1 → rsp_rdata = 0x12345678 in cycle k+2. Continuous valid load streams give one rsp_valid per cycle.
- Reset mid-operation: assert reset during a load's response cycle → rsp_valid drops to 0 immediately, init_done = 0, and a full 256-cycle re-zeroing follows. Previously stored data then reads back as 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and fault/lane helpers for the sized data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_B    = 2'b00,
    MEM_H    = 2'b01,
    MEM_W    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_e;

  // A request faults on reserved size, misalignment for its size, or out-of-range address.
  function automatic logic dmem_fault(input mem_size_e size, input logic [1:0] lane,
                                      input logic out_of_range);
    logic f;
    f = out_of_range;
    case (size)
      MEM_B:   f = f;
      MEM_H:   f = f | lane[0];
      MEM_W:   f = f | (|lane);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] dmem_byte_en(input mem_size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      MEM_B:   be = 4'b0001 << lane;
      MEM_H:   be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across lanes so the byte enables pick it up.
  function automatic logic [31:0] dmem_lane_data(input mem_size_e size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      MEM_B:   d = {4{wdata[7:0]}};
      MEM_H:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/half from a little-endian word and sign/zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  lane,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = ld_word[7:0];
    case (lane)
      2'd0:    byte_v = ld_word[7:0];
      2'd1:    byte_v = ld_word[15:8];
      2'd2:    byte_v = ld_word[23:16];
      default: byte_v = ld_word[31:24];
    endcase
    half_v = lane[1] ? ld_word[31:16] : ld_word[15:0];
  end

  always_comb begin
    rdata = ld_word;
    case (size)
      MEM_B:   rdata = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      MEM_H:   rdata = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: rdata = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressable data memory with sized loads/stores, fault flagging,
// one-cycle registered responses and a post-reset zeroing sequencer.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned IDX = $clog2(DEPTH_WORDS);
  localparam logic [IDX-1:0] LAST_IDX = IDX'(DEPTH_WORDS - 1);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_e    state_q, state_d;
  logic [IDX-1:0] cnt_q, cnt_d;
  logic           init_done_q, init_done_d;
  logic           ready_q, ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;

  logic           wr_en;
  logic [IDX-1:0] wr_idx;
  logic [3:0]     wr_be;
  logic [31:0]    wr_data;

  mem_size_e      size_e;
  logic [IDX-1:0] idx;
  logic [1:0]     lane;
  logic           out_of_range;
  logic           fault;
  logic           accept;
  logic [31:0]    rd_word;
  logic [31:0]    ld_data;

  assign size_e = mem_size_e'(req_size);
  assign idx    = req_addr[IDX+1:2];
  assign lane   = req_addr[1:0];
  assign accept = req_valid && ready_q;

  // Any set bit above the indexed range puts the address beyond the array.
  generate
    if (ADDR_W > IDX + 2) begin : g_range
      assign out_of_range = |req_addr[ADDR_W-1:IDX+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign fault   = dmem_fault(size_e, lane, out_of_range);
  assign rd_word = mem[idx];

  dmem_load_align u_align (
    .ld_word     (rd_word),
    .lane        (lane),
    .size        (size_e),
    .is_unsigned (req_unsigned),
    .rdata       (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = cnt_q;
    wr_be       = '0;
    wr_data     = '0;

    case (state_q)
      INIT: begin
        wr_en  = 1'b1;
        wr_idx = cnt_q;
        wr_be  = '1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d     = RUN;
          init_done_d = 1'b1;
          ready_d     = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = fault;
          if (!fault) begin
            if (req_we) begin
              wr_en   = 1'b1;
              wr_idx  = idx;
              wr_be   = dmem_byte_en(size_e, lane);
              wr_data = dmem_lane_data(size_e, req_wdata);
            end else begin
              rsp_rdata_d = ld_data;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed scoreboard bench for dmem_sized (DEPTH_WORDS = 256).
module tb_dmem_sized;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  exp_t q[$];
  exp_t mon_e;
  exp_t man_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rsp_count = 0;
  int   run_len = 0;
  int   max_run = 0;

  dmem_sized #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Assumes req_ready is high; leaves the request deasserted #1 after the accepting edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        rsp_count++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        check("rsp_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end else begin
        run_len = 0;
        check("idle_rdata", rsp_rdata, 32'd0);
        check("idle_err", 32'(rsp_err), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int n;

    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Hold a word load at 0x3FC through the whole zeroing phase.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_W;
    req_addr  = 32'h3FC;
    man_e.rdata = 32'h0;
    man_e.err   = 1'b0;
    q.push_back(man_e);
    check("init_ready_pre", 32'(req_ready), 32'd0);
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      check("init_ready", 32'(req_ready), 32'(i == 256));
      if (i == 255 || i == 256) check("init_done", 32'(init_done), 32'(i == 256));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    idle(1);

    // Sized stores/loads
    issue(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    issue(1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    issue(1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    issue(1'b1, SZ_B, 1'b0, 32'h11, 32'h123456AA, 32'h0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
    issue(1'b0, SZ_B, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    issue(1'b1, SZ_H, 1'b0, 32'h12, 32'hFFFF7F01, 32'h0, 1'b0);
    issue(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'h00007F01, 1'b0);
    issue(1'b0, SZ_W, 1'b1, 32'h10, 32'h0, 32'h7F01AAEF, 1'b0);
    idle(2);

    // Faults leave the array untouched
    issue(1'b1, SZ_W, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
    issue(1'b1, SZ_H, 1'b0, 32'h21, 32'h0000FFFF, 32'h0, 1'b1);
    issue(1'b1, SZ_W, 1'b0, 32'h400, 32'hBADBAD00, 32'h0, 1'b1);
    issue(1'b1, SZ_W, 1'b0, 32'h22, 32'hBADBAD01, 32'h0, 1'b1);
    issue(1'b1, SZ_R, 1'b0, 32'h20, 32'hBADBAD02, 32'h0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h00000000, 1'b0);
    issue(1'b0, SZ_R, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
    issue(1'b0, SZ_H, 1'b1, 32'h23, 32'h0, 32'h0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
    issue(1'b0, SZ_B, 1'b0, 32'h3FF, 32'h0, 32'h0, 1'b0);
    issue(1'b0, SZ_B, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);

    // Address 0 is writable
    issue(1'b1, SZ_W, 1'b0, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
    idle(2);

    // Back-to-back store then load, then an unbroken load stream
    issue(1'b1, SZ_W, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0);
    idle(2);
    max_run = 0;
    c0 = rsp_count;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: issue(1'b0, SZ_B, 1'b1, 32'h40, 32'h0, 32'h78, 1'b0);
        1: issue(1'b0, SZ_B, 1'b1, 32'h41, 32'h0, 32'h56, 1'b0);
        2: issue(1'b0, SZ_B, 1'b1, 32'h42, 32'h0, 32'h34, 1'b0);
        default: issue(1'b0, SZ_B, 1'b1, 32'h43, 32'h0, 32'h12, 1'b0);
      endcase
    end
    idle(2);
    check("stream_count", 32'(rsp_count - c0), 32'd8);
    check("stream_run", 32'(max_run), 32'd8);
    check("queue_drained", 32'(q.size()), 32'd0);

    // Reset during a load's response cycle
    issue(1'b1, SZ_W, 1'b0, 32'h80, 32'hCAFEF00D, 32'h0, 1'b0);
    idle(1);
    issue(1'b0, SZ_W, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D, 1'b0);
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    if (q.size() != 0) begin
      man_e = q.pop_front();
      check("pre_rst_rdata", rsp_rdata, man_e.rdata);
    end
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!init_done && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reinit_cycles", 32'(n), 32'd256);
    check("reinit_ready", 32'(req_ready), 32'd1);
    issue(1'b0, SZ_W, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    issue(1'b0, SZ_H, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    idle(3);
    check("final_queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
